// File: rtl/row_loader.sv
// Serial-to-parallel row loader: one cell per accepted beat, commits a WIDTH-bit row.
// Optional even-parity check per word is enabled by defining ROW_LOADER_PARITY_EN.
module row_loader #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ser_ready,
  output logic [WIDTH-1:0] row_d,
  output logic             row_we,
  output logic             busy,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef ROW_LOADER_PARITY_EN
  // Full word is kept so the parity bit can be checked against it.
  localparam int SRW = WIDTH;
`else
  // The oldest bit leaves through shift_word straight into row_d.
  localparam int SRW = WIDTH - 1;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    COMMIT
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [SRW-1:0]   sr;
  logic [WIDTH-1:0] shift_word;
  logic             accept;
  logic             data_beat;
  logic             load_row;
  logic             par_fail;

  assign ser_ready  = !reset && (state != COMMIT);
  assign accept     = ser_valid && ser_ready;
  assign data_beat  = accept && ((state == IDLE) || (state == SHIFT));
  assign shift_word = {sr[WIDTH-2:0], ser_in};
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode, commit strobe and parity verdict.
  always_comb begin
    state_nx = state;
    row_we   = 1'b0;
    load_row = 1'b0;
    par_fail = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (accept && (cnt == LAST)) begin
`ifdef ROW_LOADER_PARITY_EN
          state_nx = PARITY;
`else
          state_nx = COMMIT;
          load_row = 1'b1;
`endif
        end
      end
      PARITY: begin
`ifdef ROW_LOADER_PARITY_EN
        if (accept) begin
          if (ser_in == ^sr) begin
            state_nx = COMMIT;
            load_row = 1'b1;
          end else begin
            state_nx = IDLE;
            par_fail = 1'b1;
          end
        end
`else
        state_nx = IDLE;
`endif
      end
      COMMIT: begin
        row_we   = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Bit counter: 1 after the first bit, WIDTH after the last, cleared on exit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == COMMIT) begin
      cnt <= '0;
    end else if (accept) begin
      unique case (state)
        IDLE:    cnt <= CW'(1);
        SHIFT:   cnt <= cnt + CW'(1);
        default: cnt <= '0;
      endcase
    end
  end

  // Shift register only moves on accepted data beats, so idle X never enters.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (data_beat) begin
      sr <= shift_word[SRW-1:0];
    end
  end

  // Row output register, loaded only on entry to COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_d <= '0;
    end else if (load_row) begin
`ifdef ROW_LOADER_PARITY_EN
      row_d <= sr;
`else
      row_d <= shift_word;
`endif
    end
  end

`ifdef ROW_LOADER_PARITY_EN
  // One-cycle error pulse after a rejected parity bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= par_fail;
    end
  end
`else
  assign err = 1'b0;
  logic unused_par;
  assign unused_par = par_fail;
`endif

endmodule

// File: tb/tb_row_loader.sv
// Bench for row_loader: directed scenarios then random traffic,
// checked every cycle against a bit-list reference model.
module tb_row_loader;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         reset;
  logic         ser_in;
  logic         ser_valid;
  logic         ser_ready;
  logic [W-1:0] row_d;
  logic         row_we;
  logic         busy;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int           m_nbits;
  longint       m_acc;
  bit           m_pend;
  logic [W-1:0] m_row;
  bit           m_err;
  int           we_count;

  always #5 clk = ~clk;

  row_loader #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .row_d     (row_d),
    .row_we    (row_we),
    .busy      (busy),
    .err       (err)
  );

`ifdef ROW_LOADER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check outputs against model, clock, advance model.
  task automatic step(input logic r, input logic v, input logic b);
    bit acc_ok;
    @(negedge clk);
    reset     = r;
    ser_valid = v;
    ser_in    = v ? b : 1'bx;
    #1;
    chk1("ser_ready", ser_ready, !r && !m_pend);
    chk1("row_we", row_we, m_pend);
    chk1("busy", busy, (m_nbits > 0) || m_pend);
    chk1("err", err, m_err);
    chkw("row_d", row_d, m_row);
    if (row_we === 1'b1) we_count++;
    @(posedge clk);
    acc_ok = !r && v && !m_pend;
    m_err  = 1'b0;
    if (r) begin
      m_nbits = 0;
      m_acc   = 0;
      m_pend  = 1'b0;
      m_row   = '0;
    end else if (m_pend) begin
      m_pend = 1'b0;
    end else if (acc_ok) begin
      if (m_nbits < W) begin
        m_acc = m_acc * 2 + longint'(b);
        m_nbits++;
        if (m_nbits == W && !PAR) begin
          m_row   = W'(m_acc);
          m_pend  = 1'b1;
          m_nbits = 0;
          m_acc   = 0;
        end
      end else begin
        if (($countones(m_acc) % 2) == int'(b)) begin
          m_row  = W'(m_acc);
          m_pend = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        m_nbits = 0;
        m_acc   = 0;
      end
    end
  endtask

  // Send a word MSB first, optional gap after bit index gap_at, then parity.
  task automatic send(input logic [W-1:0] w, input int gap_at,
                      input int gap_len, input bit bad_par);
    logic [W-1:0] t;
    t = w;
    for (int i = W - 1; i >= 0; i--) begin
      step(1'b0, 1'b1, t[i]);
      if ((W - 1 - i) == gap_at) begin
        for (int g = 0; g < gap_len; g++) step(1'b0, 1'b0, 1'b0);
      end
    end
    if (PAR) step(1'b0, 1'b1, (^t) ^ bad_par);
  endtask

  initial begin
    m_nbits  = 0;
    m_acc    = 0;
    m_pend   = 1'b0;
    m_row    = '0;
    m_err    = 1'b0;
    we_count = 0;
    reset     = 1'b1;
    ser_valid = 1'b0;
    ser_in    = 1'b0;
    repeat (2) @(posedge clk);

    // reset state, ready low during reset cycle then high
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // basic word, continuous valid
    send(11'h00C, -1, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chkw("row_hold_00c", row_d, 11'h00C);

    // same word with a 3-cycle gap after bit 5
    send(11'h00C, 5, 3, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // reset mid-word, then full word
    we_count = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    send(11'h7FF, -1, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    n_cmp++;
    assert (we_count == 1) else begin
      n_bad++;
      $error("FAIL we_after_reset observed=%0d expected=1", we_count);
    end

    // back to back words, valid held high through the bubble
    we_count = 0;
    send(11'h555, -1, 0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    send(11'h2AA, -1, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    n_cmp++;
    assert (we_count == 2) else begin
      n_bad++;
      $error("FAIL we_b2b observed=%0d expected=2", we_count);
    end
    chkw("row_b2b", row_d, 11'h2AA);

    // parity scenarios
    if (PAR) begin
      send(11'h00C, -1, 0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      send(11'h00C, -1, 0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end

    // reset during a commit
    send(11'h3C5, -1, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // random traffic with occasional resets
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom));
    end
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
